// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests
// and buffers returned words in a 2-entry queue presented to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_next,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_IDLE = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  logic [31:0] r_q_word [2];
  logic [31:0] r_q_pcn  [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_wr_idx;
  logic [1:0]  w_count_nxt;
  logic [31:0] w_pc_inc;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];
  assign w_pc_inc      = r_pc + 32'd4;

  // A redirect outranks both the memory response and the decode pop.
  assign w_push      = (r_state == S_REQ) && imem_ack && !redirect;
  assign w_pop       = we && (r_count != 2'd0) && !redirect;
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_wr_idx    = r_head ^ r_count[0];

  assign imem_req  = reset && (r_state != S_IDLE);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign fetch_valid = (r_count != 2'd0);
  assign instruction = fetch_valid ? r_q_word[r_head] : NOP_WORD;
  assign pc_next     = fetch_valid ? r_q_pcn[r_head]  : 32'd0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (redirect)
          w_state_nxt = imem_ack ? S_REQ : S_DROP;
        else if (imem_ack)
          w_state_nxt = (w_count_nxt == 2'd2) ? S_IDLE : S_REQ;
      end
      S_IDLE: begin
        if (redirect || w_pop)
          w_state_nxt = S_REQ;
      end
      S_DROP: begin
        if (imem_ack)
          w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect)
        r_pc <= w_redirect_pc;
      else if (w_push)
        r_pc <= w_pc_inc;
      if (redirect) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        if (w_pop)
          r_head <= ~r_head;
      end
    end
  end

  // Queue payload and the stale address need no reset; r_count gates their use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_word[w_wr_idx] <= imem_rdata;
      r_q_pcn[w_wr_idx]  <= w_pc_inc;
    end
    if ((r_state == S_REQ) && redirect && !imem_ack)
      r_drop_addr <= r_pc;
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: decode must see the program-order address
// stream (sequential from reset or the last redirect target) with mem[a]=a^A5A5A5A5.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam logic [31:0] NOP_WORD = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        we;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_next;
  logic        fetch_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;

  logic [31:0] sb [$];
  logic [31:0] sb_tail;

  int unsigned mem_lat_min = 0;
  int unsigned mem_lat_max = 0;
  int          mem_cnt     = 0;
  logic        mem_busy    = 1'b0;
  logic [31:0] mem_addr    = 32'd0;
  logic [31:0] mon_addr;
  logic [31:0] exp_next;

  if_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
    .clk(clk), .reset(reset), .we(we), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .pc_next(pc_next), .fetch_valid(fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_topup();
    while (sb.size() < 8) begin
      sb.push_back(sb_tail);
      sb_tail = sb_tail + 32'd4;
    end
  endtask

  task automatic sb_reset(input logic [31:0] target);
    sb.delete();
    sb_tail = {target[31:2], 2'b00};
    sb_topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_topup();
  endtask

  task automatic set_lat(input int unsigned lo, input int unsigned hi);
    mem_lat_min = lo;
    mem_lat_max = hi;
  endtask

  // Memory: acks after a random number of wait cycles, checks address hold.
  always @(negedge clk) begin
    if (!reset) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end else begin
      if (mem_busy) chk("req_held", {31'b0, imem_req}, 32'd1);
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_addr = imem_addr;
          mem_cnt  = int'($urandom_range(mem_lat_max, mem_lat_min));
        end else begin
          chk("addr_stable", imem_addr, mem_addr);
        end
        if (mem_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          mem_busy   = 1'b0;
        end else begin
          mem_cnt--;
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEADBEEF;
        end
      end else begin
        mem_busy = 1'b0;
        imem_ack = 1'b0;
      end
    end
  end

  // Monitor: every accepted head must be the next program-order instruction.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (!fetch_valid) begin
        chk("bubble_instr", instruction, NOP_WORD);
        chk("bubble_pcn", pc_next, 32'd0);
      end else if (we && !redirect) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          mon_addr = sb.pop_front();
          chk("head_instr", instruction, memf(mon_addr));
          chk("head_pcn", pc_next, mon_addr + 32'd4);
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit found;
    reset = 1'b0; we = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    sb_reset(RESET_PC);
    set_lat(0, 0);
    step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction, NOP_WORD);
    chk("rst_pcn", pc_next, 32'd0);

    // 1: reset release, zero-wait memory, continuous consume
    reset = 1'b1; we = 1'b1;
    #1;
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, RESET_PC);
    step();
    chk("t1_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t1_instr", instruction, memf(RESET_PC));
    chk("t1_pcn", pc_next, RESET_PC + 32'd4);
    p0 = pop_cnt;
    repeat (20) step();
    chk("t1_rate", 32'(pop_cnt - p0), 32'd20);

    // 2: decode stalls, queue fills, fetch idles
    we = 1'b0;
    repeat (5) step();
    chk("t2_req", {31'b0, imem_req}, 32'd0);
    chk("t2_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t2_head", instruction, memf(sb[0]));
    chk("t2_head_pcn", pc_next, sb[0] + 32'd4);
    we = 1'b1;
    step();
    exp_next = sb[0] + 32'd4;
    chk("t2_rereq", {31'b0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, exp_next);
    set_lat(3, 3);

    // 3: redirect while a slow request is outstanding
    step();
    redirect = 1'b1; redirect_pc = 32'h00400002;
    sb_reset(32'h00400002);
    step();
    redirect = 1'b0;
    chk("t3_hold_addr", imem_addr, exp_next);
    chk("t3_hold_req", {31'b0, imem_req}, 32'd1);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req && imem_addr == 32'h00400000) found = 1;
      else step();
    end
    chk("t3_new_addr", imem_addr, 32'h00400000);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fetch_valid) found = 1;
      else step();
    end
    chk("t3_first_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t3_first_pcn", pc_next, 32'h00400004);

    // 4a: redirect coincident with an ack
    set_lat(0, 0);
    repeat (8) step();
    redirect = 1'b1; redirect_pc = 32'h00001230;
    sb_reset(32'h00001230);
    step();
    redirect = 1'b0;
    chk("t4a_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t4a_instr", instruction, NOP_WORD);
    chk("t4a_addr", imem_addr, 32'h00001230);
    chk("t4a_req", {31'b0, imem_req}, 32'd1);

    // 4b: redirect with a full queue and we=1
    we = 1'b0;
    repeat (4) step();
    chk("t4b_full_valid", {31'b0, fetch_valid}, 32'd1);
    chk("t4b_idle_req", {31'b0, imem_req}, 32'd0);
    chk("t4b_head", instruction, memf(sb[0]));
    we = 1'b1; redirect = 1'b1; redirect_pc = 32'h00002340;
    sb_reset(32'h00002340);
    step();
    redirect = 1'b0;
    chk("t4b_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t4b_pcn", pc_next, 32'd0);
    chk("t4b_addr", imem_addr, 32'h00002340);
    chk("t4b_req", {31'b0, imem_req}, 32'd1);

    // 5: address wrap at the top of memory
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    sb_reset(32'hFFFFFFFC);
    step();
    redirect = 1'b0;
    chk("t5_addr", imem_addr, 32'hFFFFFFFC);
    step();
    chk("t5_instr0", instruction, memf(32'hFFFFFFFC));
    chk("t5_pcn0", pc_next, 32'h00000000);
    step();
    chk("t5_instr1", instruction, memf(32'h00000000));
    chk("t5_pcn1", pc_next, 32'h00000004);

    // 6: reset asserted while a request waits
    set_lat(2, 2);
    we = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    sb_reset(RESET_PC);
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t6_instr", instruction, NOP_WORD);
    chk("t6_pcn", pc_next, 32'd0);
    step(); step();
    reset = 1'b1;
    #1;
    chk("t6_rel_req", {31'b0, imem_req}, 32'd1);
    chk("t6_rel_addr", imem_addr, RESET_PC);
    we = 1'b1;

    // Random traffic: stalls, redirects and variable memory latency
    set_lat(0, 3);
    for (int i = 0; i < 1500; i++) begin
      step();
      we = ($urandom_range(9, 0) < 7);
      redirect = ($urandom_range(49, 0) == 0);
      redirect_pc = $urandom;
      if (redirect) sb_reset(redirect_pc);
    end
    step();
    redirect = 1'b0; we = 1'b1;
    set_lat(0, 0);
    p0 = pop_cnt;
    repeat (12) step();
    chk("final_progress", {31'b0, (pop_cnt - p0) >= 8}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
